sargantana_icache_refill_ctrl: RTL
==================================

# sargantana_icache_refill_ctrl

Initiator-side controller for the instruction cache tag/data memory. It accepts a miss (tag, set index, victim way), fetches the line from L2 over a valid/ready request and a valid-only response, and writes tag, valid bit and line into the selected way. It also sequences whole-cache flushes. It sits between the icache miss logic and the memory's req/we/flush port set, and is the only writer of that memory.

## Interface
Parameters:
- N_WAY, 4, number of ways; one-hot way select width
- IDX_W, 6, set index width
- TAG_W, 20, tag width
- LINE_W, 128, cache line width
- ADDR_W, IDX_W+2, memory address width; index occupies [ADDR_W-1:2]
- TIMEOUT, 255, response watchdog limit in cycles (used only with the watchdog compiled in)

Ports (one clock `clk_i`; reset `rstn_i` is asynchronous, active-low):
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- miss_valid_i  in  1  miss request valid
- miss_ready_o  out  1  miss accepted when high together with miss_valid_i
- miss_tag_i  in  TAG_W  tag of the missing line
- miss_idx_i  in  IDX_W  set index
- miss_way_i  in  N_WAY  one-hot victim way
- flush_i  in  1  flush request pulse
- flush_done_o  out  1  one-cycle pulse, flush issued
- l2_req_valid_o  out  1  L2 request valid
- l2_req_ready_i  in  1  L2 request accepted
- l2_req_addr_o  out  TAG_W+IDX_W  line address {tag, idx}
- l2_rsp_valid_i  in  1  L2 response valid (no backpressure)
- l2_rsp_data_i  in  LINE_W  response line
- l2_rsp_error_i  in  1  response carries an error
- tag_req_o  out  N_WAY  tag array way request
- data_req_o  out  N_WAY  data array way request
- tag_we_o  out  1  tag write enable
- data_we_o  out  1  data write enable
- flush_en_o  out  1  tag array flush (clear all valid bits)
- valid_bit_o  out  1  valid bit to write
- cline_o  out  LINE_W  line to write
- tag_o  out  TAG_W  tag to write
- addr_o  out  ADDR_W  {idx, 2'b00}
- fill_done_o  out  1  one-cycle pulse, line written
- fill_error_o  out  1  one-cycle pulse, fill aborted
- busy_o  out  1  state != IDLE

## Operation
- FSM states: IDLE, REQ, WAIT, WRITE, FLUSH.
- IDLE: miss_ready_o = !flush_i. flush_i → FLUSH (flush wins over a same-cycle miss). Miss handshake → latch tag/idx/way, go to REQ.
- REQ: l2_req_valid_o = 1 and address held stable until l2_req_ready_i; then go to WAIT.
- WAIT: on l2_rsp_valid_i:
  - error → fill_error_o, go to IDLE, no memory write
  - flush pending → drop the line, go to FLUSH
  - otherwise latch data, go to WRITE
- WRITE (one cycle): tag_req_o = data_req_o = latched way, tag_we_o = data_we_o = valid_bit_o = 1, tag_o/cline_o/addr_o from latched values, fill_done_o = 1. Next state: FLUSH if a flush is pending, else IDLE.
- FLUSH (one cycle): flush_en_o = 1, tag_req_o = all ones, tag_we_o = 1, valid_bit_o = 0, flush_done_o = 1. Clears the pending flag. Next state: IDLE.
- flush_i in REQ/WAIT/WRITE sets a sticky pending flag. Multiple pulses collapse to one flush.
- l2_rsp_valid_i outside WAIT is ignored, including late responses after a timeout.
- Outside WRITE/FLUSH, all memory req/we outputs are 0. Data outputs hold their last latched values.

## Timing
- Reset value of every output is 0, except miss_ready_o = 1 (IDLE, flush_i low).
- Miss accepted at cycle T. l2_req_valid_o is high from T+1. With ready at T+1 and response at T+2, the write occurs at T+3.
- flush_i in IDLE at T: flush_en_o and flush_done_o at T+1; miss_ready_o returns at T+2.
- Reset asserted mid-fill: returns to IDLE immediately; no write and no done/error pulse are produced.

## Configuration
- `ICACHE_REFILL_WATCHDOG_EN` defined: an 8-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT with no response, the block pulses fill_error_o and goes to IDLE, or to FLUSH if a flush is pending.
- `ICACHE_REFILL_WATCHDOG_EN` undefined: no counter; WAIT holds indefinitely.

## Test plan
- Miss tag 0x12345, idx 5, way 4'b0100; ready immediately; response 0xA5…A5 after 3 cycles -> one WRITE cycle with tag_we_o = data_we_o = 1, tag_req_o = 4'b0100, addr_o = 0x14, cline_o = 0xA5…A5, fill_done_o pulse.
- l2_req_ready_i held low 4 cycles -> l2_req_valid_o and l2_req_addr_o = 0x48D145 stable all 5 cycles; miss_ready_o = 0 throughout.
- Response with l2_rsp_error_i = 1 -> fill_error_o pulse; no req/we asserted; IDLE next cycle.
- flush_i pulsed twice during WAIT, then response arrives -> no WRITE; exactly one FLUSH cycle (flush_en_o = 1, tag_req_o = 4'b1111); one flush_done_o.
- flush_i and miss_valid_i in the same IDLE cycle -> miss_ready_o = 0, FLUSH next; miss accepted after return to IDLE.
- With the watchdog, TIMEOUT = 8 and no response -> fill_error_o 8 cycles after entering WAIT; a later l2_rsp_valid_i causes no write.

Source files
------------

// File: rtl/sargantana_icache_refill_ctrl_if.sv
// Signal bundle between the icache refill controller and its neighbours (miss logic, L2, tag/data memory).
// master = the refill controller, slave = the surrounding cache, L2 and memory side.
interface sargantana_icache_refill_ctrl_if #(
  parameter int N_WAY  = 4,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 20,
  parameter int LINE_W = 128,
  parameter int ADDR_W = IDX_W + 2
);
  logic                   miss_valid_i;
  logic                   miss_ready_o;
  logic [TAG_W-1:0]       miss_tag_i;
  logic [IDX_W-1:0]       miss_idx_i;
  logic [N_WAY-1:0]       miss_way_i;
  logic                   flush_i;
  logic                   flush_done_o;
  logic                   l2_req_valid_o;
  logic                   l2_req_ready_i;
  logic [TAG_W+IDX_W-1:0] l2_req_addr_o;
  logic                   l2_rsp_valid_i;
  logic [LINE_W-1:0]      l2_rsp_data_i;
  logic                   l2_rsp_error_i;
  logic [N_WAY-1:0]       tag_req_o;
  logic [N_WAY-1:0]       data_req_o;
  logic                   tag_we_o;
  logic                   data_we_o;
  logic                   flush_en_o;
  logic                   valid_bit_o;
  logic [LINE_W-1:0]      cline_o;
  logic [TAG_W-1:0]       tag_o;
  logic [ADDR_W-1:0]      addr_o;
  logic                   fill_done_o;
  logic                   fill_error_o;
  logic                   busy_o;

  modport master (
    input  miss_valid_i, miss_tag_i, miss_idx_i, miss_way_i, flush_i,
           l2_req_ready_i, l2_rsp_valid_i, l2_rsp_data_i, l2_rsp_error_i,
    output miss_ready_o, flush_done_o, l2_req_valid_o, l2_req_addr_o,
           tag_req_o, data_req_o, tag_we_o, data_we_o, flush_en_o, valid_bit_o,
           cline_o, tag_o, addr_o, fill_done_o, fill_error_o, busy_o
  );

  modport slave (
    output miss_valid_i, miss_tag_i, miss_idx_i, miss_way_i, flush_i,
           l2_req_ready_i, l2_rsp_valid_i, l2_rsp_data_i, l2_rsp_error_i,
    input  miss_ready_o, flush_done_o, l2_req_valid_o, l2_req_addr_o,
           tag_req_o, data_req_o, tag_we_o, data_we_o, flush_en_o, valid_bit_o,
           cline_o, tag_o, addr_o, fill_done_o, fill_error_o, busy_o
  );
endinterface

// File: rtl/sargantana_icache_refill_ctrl.sv
// Icache refill controller: fetches a missing line from L2, writes it into the victim way, sequences flushes.
// Optional response watchdog compiled in with `define ICACHE_REFILL_WATCHDOG_EN.
module sargantana_icache_refill_ctrl #(
  parameter int N_WAY   = 4,
  parameter int IDX_W   = 6,
  parameter int TAG_W   = 20,
  parameter int LINE_W  = 128,
  parameter int ADDR_W  = IDX_W + 2,
  parameter int TIMEOUT = 255
) (
  input logic clk_i,
  input logic rstn_i,
  sargantana_icache_refill_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    WRITE,
    FLUSH
  } state_e;

  state_e state_q, state_d;
  logic              pending_q, pending_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_WAY-1:0]  way_q, way_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic             l2_req_valid_q, l2_req_valid_d;
  logic [N_WAY-1:0] tag_req_q, tag_req_d;
  logic [N_WAY-1:0] data_req_q, data_req_d;
  logic             tag_we_q, tag_we_d;
  logic             data_we_q, data_we_d;
  logic             flush_en_q, flush_en_d;
  logic             valid_bit_q, valid_bit_d;
  logic             fill_done_q, fill_done_d;
  logic             fill_error_q, fill_error_d;
  logic             flush_done_q, flush_done_d;

  logic flush_req;
  logic miss_fire;
  logic wd_expire;

  // A flush is owed if one was seen earlier in this fill or is being requested right now.
  assign flush_req = pending_q | bus.flush_i;
  assign miss_fire = (state_q == IDLE) && bus.miss_valid_i && !flush_req;

`ifdef ICACHE_REFILL_WATCHDOG_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

  assign wd_cnt_d  = (state_q == WAIT) ? wd_cnt_q + 1'b1 : '0;
  assign wd_expire = (state_q == WAIT) && (wd_cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    way_d        = way_q;
    line_d       = line_q;
    fill_error_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
        end else if (bus.miss_valid_i) begin
          tag_d   = bus.miss_tag_i;
          idx_d   = bus.miss_idx_i;
          way_d   = bus.miss_way_i;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.flush_i) pending_d = 1'b1;
        if (bus.l2_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (bus.flush_i) pending_d = 1'b1;
        if (bus.l2_rsp_valid_i) begin
          if (bus.l2_rsp_error_i) begin
            fill_error_d = 1'b1;
            state_d      = IDLE;
          end else if (flush_req) begin
            state_d = FLUSH;
          end else begin
            line_d  = bus.l2_rsp_data_i;
            state_d = WRITE;
          end
        end else if (wd_expire) begin
          fill_error_d = 1'b1;
          state_d      = flush_req ? FLUSH : IDLE;
        end
      end
      WRITE: begin
        if (bus.flush_i) pending_d = 1'b1;
        state_d = flush_req ? FLUSH : IDLE;
      end
      FLUSH: begin
        pending_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Memory strobes are decoded from the next state so they appear as clean flops.
    l2_req_valid_d = (state_d == REQ);
    tag_req_d      = (state_d == WRITE) ? way_d :
                     (state_d == FLUSH) ? {N_WAY{1'b1}} : '0;
    data_req_d     = (state_d == WRITE) ? way_d : '0;
    tag_we_d       = (state_d == WRITE) || (state_d == FLUSH);
    data_we_d      = (state_d == WRITE);
    valid_bit_d    = (state_d == WRITE);
    flush_en_d     = (state_d == FLUSH);
    fill_done_d    = (state_d == WRITE);
    flush_done_d   = (state_d == FLUSH);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q        <= IDLE;
      pending_q      <= 1'b0;
      tag_q          <= '0;
      idx_q          <= '0;
      way_q          <= '0;
      line_q         <= '0;
      l2_req_valid_q <= 1'b0;
      tag_req_q      <= '0;
      data_req_q     <= '0;
      tag_we_q       <= 1'b0;
      data_we_q      <= 1'b0;
      flush_en_q     <= 1'b0;
      valid_bit_q    <= 1'b0;
      fill_done_q    <= 1'b0;
      fill_error_q   <= 1'b0;
      flush_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      tag_q          <= tag_d;
      idx_q          <= idx_d;
      way_q          <= way_d;
      line_q         <= line_d;
      l2_req_valid_q <= l2_req_valid_d;
      tag_req_q      <= tag_req_d;
      data_req_q     <= data_req_d;
      tag_we_q       <= tag_we_d;
      data_we_q      <= data_we_d;
      flush_en_q     <= flush_en_d;
      valid_bit_q    <= valid_bit_d;
      fill_done_q    <= fill_done_d;
      fill_error_q   <= fill_error_d;
      flush_done_q   <= flush_done_d;
    end
  end

  assign bus.miss_ready_o   = miss_fire || ((state_q == IDLE) && !flush_req);
  assign bus.l2_req_valid_o = l2_req_valid_q;
  assign bus.l2_req_addr_o  = {tag_q, idx_q};
  assign bus.tag_req_o      = tag_req_q;
  assign bus.data_req_o     = data_req_q;
  assign bus.tag_we_o       = tag_we_q;
  assign bus.data_we_o      = data_we_q;
  assign bus.flush_en_o     = flush_en_q;
  assign bus.valid_bit_o    = valid_bit_q;
  assign bus.cline_o        = line_q;
  assign bus.tag_o          = tag_q;
  assign bus.addr_o         = {idx_q, 2'b00};
  assign bus.fill_done_o    = fill_done_q;
  assign bus.fill_error_o   = fill_error_q;
  assign bus.flush_done_o   = flush_done_q;
  assign bus.busy_o         = (state_q != IDLE);

endmodule
